// File: rtl/hist_mmio_pkg.sv
// Shared definitions for the histogram/CDF accelerator: register offsets, FSM states and counter arithmetic.
// Build with HIST_SATURATE_EN defined for saturating counters; the default build wraps modulo 2^CNT_W.
package hist_mmio_pkg;

    localparam logic [9:0] OFF_CTRL     = 10'h000;
    localparam logic [9:0] OFF_PIXEL    = 10'h001;
    localparam logic [9:0] OFF_TOTAL    = 10'h002;
    localparam logic [9:0] OFF_BIN_BASE = 10'h100;

    localparam int CTRL_CLEAR_BIT = 0;
    localparam int CTRL_CDF_BIT   = 1;

    localparam int IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        CDF   = 2'd2
    } hist_state_t;

    // Operands are zero-extended counters; only the low w bits of the result are meaningful.
    function automatic logic [31:0] hist_add(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        lim = (33'd1 << w) - 33'd1;
        sum = {1'b0, a} + {1'b0, b};
`ifdef HIST_SATURATE_EN
        if (sum > lim) sum = lim;
`else
        sum = sum & lim;
`endif
        return sum[31:0];
    endfunction

endpackage

// File: rtl/hist_bin_array.sv
// NBINS x CNT_W counter storage: two asynchronous read ports (core, FSM) and one synchronous write port.
// Every bin clears asynchronously on rst_i.
module hist_bin_array #(
    parameter int NBINS = 256,
    parameter int CNT_W = 20,
    parameter int AW    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    core_raddr_i,
    output logic [CNT_W-1:0] core_rdata_o,
    input  logic [AW-1:0]    fsm_raddr_i,
    output logic [CNT_W-1:0] fsm_rdata_o,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [CNT_W-1:0] wdata_i
);

    logic [CNT_W-1:0] bin_q [NBINS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBINS; i++) bin_q[i] <= '0;
        end else if (we_i) begin
            bin_q[waddr_i] <= wdata_i;
        end
    end

    assign core_rdata_o = bin_q[core_raddr_i];
    assign fsm_rdata_o  = bin_q[fsm_raddr_i];

endmodule

// File: rtl/hist_mmio.sv
// Memory-mapped pixel histogram with in-place CLEAR and CDF sequences; reads are zero-latency and never stall.
// HIST_SATURATE_EN selects saturating bin/total/CDF arithmetic; otherwise counters wrap.
module hist_mmio
    import hist_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          NBINS     = 256,
    parameter int          CNT_W     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        Busy
);

    hist_state_t      state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] total_q;
    logic             cdf_valid_q;
    logic             busy_q;

    logic [9:0]       offset;
    logic             wr_ctrl;
    logic             wr_pixel;
    logic             pixel_ok;
    logic             last_idx;

    logic [IDX_W-1:0] fsm_raddr;
    logic [CNT_W-1:0] fsm_rdata;
    logic [CNT_W-1:0] core_rdata;
    logic             bin_we_d;
    logic [CNT_W-1:0] bin_wdata_d;

    logic [31:0]      bin_inc_w;
    logic [31:0]      total_inc_w;
    logic [31:0]      cdf_sum_w;

    assign offset   = ALUResult[11:2];
    assign Hit      = (ALUResult[31:12] == BASE_ADDR[31:12]);
    assign wr_ctrl  = MemWrite && Hit && (offset == OFF_CTRL);
    assign wr_pixel = MemWrite && Hit && (offset == OFF_PIXEL);
    assign pixel_ok = wr_pixel && (state_q == IDLE) && !cdf_valid_q;
    assign last_idx = (idx_q == IDX_W'(NBINS - 1));
    assign Busy     = busy_q;

    // The FSM port serves the pixel increment when idle and the sweep index otherwise.
    assign fsm_raddr = (state_q == IDLE) ? WriteData[IDX_W-1:0] : idx_q;

    assign bin_inc_w   = hist_add({{(32-CNT_W){1'b0}}, fsm_rdata}, 32'd1, CNT_W);
    assign total_inc_w = hist_add({{(32-CNT_W){1'b0}}, total_q}, 32'd1, CNT_W);
    assign cdf_sum_w   = hist_add({{(32-CNT_W){1'b0}}, acc_q},
                                  {{(32-CNT_W){1'b0}}, fsm_rdata}, CNT_W);

    always_comb begin
        bin_we_d    = 1'b0;
        bin_wdata_d = '0;
        case (state_q)
            IDLE: begin
                bin_we_d    = pixel_ok;
                bin_wdata_d = bin_inc_w[CNT_W-1:0];
            end
            CLEAR: begin
                bin_we_d    = 1'b1;
                bin_wdata_d = '0;
            end
            CDF: begin
                bin_we_d    = 1'b1;
                bin_wdata_d = cdf_sum_w[CNT_W-1:0];
            end
            default: begin
                bin_we_d    = 1'b0;
                bin_wdata_d = '0;
            end
        endcase
    end

    hist_bin_array #(
        .NBINS (NBINS),
        .CNT_W (CNT_W),
        .AW    (IDX_W)
    ) u_bins (
        .clk_i        (clk),
        .rst_i        (reset),
        .core_raddr_i (offset[IDX_W-1:0]),
        .core_rdata_o (core_rdata),
        .fsm_raddr_i  (fsm_raddr),
        .fsm_rdata_o  (fsm_rdata),
        .we_i         (bin_we_d),
        .waddr_i      (fsm_raddr),
        .wdata_i      (bin_wdata_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            total_q     <= '0;
            cdf_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // CLEAR has priority when both command bits are set.
                    if (wr_ctrl && WriteData[CTRL_CLEAR_BIT]) begin
                        state_q <= CLEAR;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (wr_ctrl && WriteData[CTRL_CDF_BIT] && !cdf_valid_q) begin
                        state_q <= CDF;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                    if (pixel_ok) total_q <= total_inc_w[CNT_W-1:0];
                end
                CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (last_idx) begin
                        total_q     <= '0;
                        cdf_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                CDF: begin
                    acc_q <= cdf_sum_w[CNT_W-1:0];
                    idx_q <= idx_q + 1'b1;
                    if (last_idx) begin
                        cdf_valid_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ReadData = '0;
        if (Hit) begin
            if (offset == OFF_CTRL) begin
                ReadData = {30'b0, cdf_valid_q, busy_q};
            end else if (offset == OFF_TOTAL) begin
                ReadData[CNT_W-1:0] = total_q;
            end else if (offset[9:8] == OFF_BIN_BASE[9:8]) begin
                ReadData[CNT_W-1:0] = core_rdata;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ALUResult[1:0], WriteData[31:IDX_W], bin_inc_w[31:CNT_W],
                           total_inc_w[31:CNT_W], cdf_sum_w[31:CNT_W]};

endmodule
